// File: rtl/lif_array.sv
// ---------------------------------------------------------------------------
// lif_array -- array of independent leaky integrate-and-fire neurons.
//
// Each channel holds an unsigned membrane potential v. On a time step
// (step=1) a channel that is not refractory leaks by v >> leak_shift,
// integrates its input current, saturates at 2^WIDTH-1 and fires if the
// result reaches the shared threshold. A firing channel resets (to zero or
// by subtracting the threshold) and enters a refractory period of
// refrac_len steps during which its input is ignored.
//
// Ports
//   clk          clock, rising edge
//   reset_n      synchronous active-low reset (overrides step)
//   step         time-step strobe
//   current      CHANNELS x WIDTH unsigned input currents, channel i at [i*WIDTH +: WIDTH]
//   threshold    shared firing threshold, 0 disables firing
//   leak_shift   decay shift, 0 disables leak
//   refrac_len   refractory steps after a spike
//   reset_mode   0 = reset-to-zero, 1 = reset-by-subtraction
//   spike        registered one-cycle spike pulse per channel
//   membrane     registered membrane potentials, same packing as current
//   spike_total  saturating count of all spikes emitted
// ---------------------------------------------------------------------------
module lif_array #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int REFRAC_BITS = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      step,
    input  logic [CHANNELS*WIDTH-1:0] current,
    input  logic [WIDTH-1:0]          threshold,
    input  logic [2:0]                leak_shift,
    input  logic [REFRAC_BITS-1:0]    refrac_len,
    input  logic                      reset_mode,
    output logic [CHANNELS-1:0]       spike,
    output logic [CHANNELS*WIDTH-1:0] membrane,
    output logic [15:0]               spike_total
);

    logic [CHANNELS-1:0] spike_d;
    logic [CHANNELS-1:0] spike_q;
    logic [15:0]         total_d;
    logic [15:0]         total_q;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0]       v_q;
            logic [WIDTH-1:0]       v_d;
            logic [REFRAC_BITS-1:0] rc_q;
            logic [REFRAC_BITS-1:0] rc_d;
            logic                   spk_d;
            logic [WIDTH-1:0]       cur;
            logic [WIDTH-1:0]       leak;
            logic [WIDTH:0]         v_raw;
            logic [WIDTH-1:0]       v_sat;
            logic                   fire;

            assign cur = current[gi*WIDTH +: WIDTH];

            always_comb begin
                leak  = (leak_shift == 3'd0) ? '0 : (v_q >> leak_shift);
                // leak <= v, so the subtraction cannot underflow; the extra
                // bit only catches the carry out of the current addition.
                v_raw = {1'b0, v_q} - {1'b0, leak} + {1'b0, cur};
                v_sat = v_raw[WIDTH] ? {WIDTH{1'b1}} : v_raw[WIDTH-1:0];
                fire  = (threshold != '0) && (v_sat >= threshold);

                v_d   = v_q;
                rc_d  = rc_q;
                spk_d = 1'b0;
                if (step) begin
                    if (rc_q != '0) begin
                        rc_d = rc_q - 1'b1;
                    end else if (fire) begin
                        spk_d = 1'b1;
                        v_d   = reset_mode ? (v_sat - threshold) : '0;
                        rc_d  = refrac_len;
                    end else begin
                        v_d = v_sat;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    v_q  <= '0;
                    rc_q <= '0;
                end else begin
                    v_q  <= v_d;
                    rc_q <= rc_d;
                end
            end

            assign spike_d[gi]                  = spk_d;
            assign membrane[gi*WIDTH +: WIDTH]  = v_q;
        end
    endgenerate

    // The counter is advanced by the spikes being registered this cycle so
    // that spike_total is coherent with the spike vector shown alongside it.
    always_comb begin
        logic [16:0] sum;
        sum = {1'b0, total_q};
        for (int i = 0; i < CHANNELS; i++) begin
            sum = sum + {16'd0, spike_d[i]};
        end
        total_d = (sum > 17'd65535) ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            spike_q <= '0;
            total_q <= '0;
        end else begin
            spike_q <= spike_d;
            total_q <= total_d;
        end
    end

    assign spike       = spike_q;
    assign spike_total = total_q;

endmodule

// File: tb/tb_lif_array.sv
module tb_lif_array;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        step;
    logic [31:0] current;
    logic [7:0]  threshold;
    logic [2:0]  leak_shift;
    logic [2:0]  refrac_len;
    logic        reset_mode;
    logic [3:0]  spike;
    logic [31:0] membrane;
    logic [15:0] spike_total;

    always #5 clk = ~clk;

    lif_array #(.WIDTH(8), .CHANNELS(4), .REFRAC_BITS(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .step        (step),
        .current     (current),
        .threshold   (threshold),
        .leak_shift  (leak_shift),
        .refrac_len  (refrac_len),
        .reset_mode  (reset_mode),
        .spike       (spike),
        .membrane    (membrane),
        .spike_total (spike_total)
    );

    int cur [4];
    always_comb current = {cur[3][7:0], cur[2][7:0], cur[1][7:0], cur[0][7:0]};

    typedef struct {
        logic [3:0]  spk;
        logic [31:0] mem;
        logic [15:0] tot;
    } exp_t;
    exp_t sbq [$];

    // reference neuron state
    int mv [4];
    int mrc [4];
    int mtot;

    int  tests = 0;
    int  fails = 0;
    bit  verbose = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance the reference by one clock and push what the DUT must show after it.
    task automatic model_clock(input bit rst, input bit st);
        exp_t e;
        int   raw;
        e.spk = 4'b0000;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin mv[i] = 0; mrc[i] = 0; end
            mtot = 0;
        end else if (st) begin
            for (int i = 0; i < 4; i++) begin
                if (mrc[i] > 0) begin
                    mrc[i] = mrc[i] - 1;
                end else begin
                    raw = mv[i] + cur[i] - ((leak_shift == 0) ? 0 : (mv[i] >> leak_shift));
                    if (raw > 255) raw = 255;
                    if (threshold != 0 && raw >= int'(threshold)) begin
                        e.spk[i] = 1'b1;
                        mv[i]  = reset_mode ? raw - int'(threshold) : 0;
                        mrc[i] = int'(refrac_len);
                        mtot   = (mtot >= 65535) ? 65535 : mtot + 1;
                    end else begin
                        mv[i] = raw;
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) e.mem[i*8 +: 8] = mv[i][7:0];
        e.tot = mtot[15:0];
        sbq.push_back(e);
    endtask

    // One transaction: drive, advance model, clock, then pop and compare.
    task automatic cyc(input bit rst, input bit st);
        exp_t e;
        reset_n = ~rst;
        step    = st;
        model_clock(rst, st);
        @(posedge clk);
        #1;
        chk("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("spike", {28'd0, spike}, {28'd0, e.spk});
            chk("membrane", membrane, e.mem);
            chk("spike_total", {16'd0, spike_total}, {16'd0, e.tot});
            if (verbose)
                $display("[TB] rst=%0d step=%0d spike=%b membrane=%h total=%0d",
                         rst, st, spike, membrane, spike_total);
        end
        reset_n = 1'b1;
        step    = 1'b0;
    endtask

    task automatic set_cfg(input int thr, input int ls, input int rl, input bit md);
        threshold  = thr[7:0];
        leak_shift = ls[2:0];
        refrac_len = rl[2:0];
        reset_mode = md;
    endtask

    task automatic set_cur(input int c0, input int c1, input int c2, input int c3);
        cur[0] = c0; cur[1] = c1; cur[2] = c2; cur[3] = c3;
    endtask

    initial begin
        reset_n = 1'b0;
        step    = 1'b0;
        set_cur(0, 0, 0, 0);
        set_cfg(0, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin mv[i] = 0; mrc[i] = 0; end
        mtot = 0;
        @(posedge clk);
        #1;

        // Reset state
        cyc(1, 1);
        chk("reset_membrane", membrane, 32'd0);
        chk("reset_spike", {28'd0, spike}, 32'd0);

        // Leaky integration, reset-to-zero
        set_cfg(180, 1, 0, 1'b0);
        set_cur(100, 0, 0, 0);
        cyc(0, 1); chk("leak_v1", {24'd0, membrane[7:0]}, 32'd100);
        cyc(0, 1); chk("leak_v2", {24'd0, membrane[7:0]}, 32'd150);
        cyc(0, 1); chk("leak_v3", {24'd0, membrane[7:0]}, 32'd175);
        cyc(0, 1); chk("leak_spike", {28'd0, spike}, 32'd1);
        chk("leak_v4_zero", {24'd0, membrane[7:0]}, 32'd0);
        chk("leak_total", {16'd0, spike_total}, 32'd1);
        // No step: spike drops, state holds
        cyc(0, 0); chk("idle_spike", {28'd0, spike}, 32'd0);
        chk("idle_total", {16'd0, spike_total}, 32'd1);

        // Same stimulus, reset-by-subtraction
        cyc(1, 0);
        set_cfg(180, 1, 0, 1'b1);
        repeat (4) cyc(0, 1);
        chk("sub_spike", {28'd0, spike}, 32'd1);
        chk("sub_v4", {24'd0, membrane[7:0]}, 32'd8);

        // Threshold zero: saturation, never fires
        cyc(1, 0);
        set_cfg(0, 0, 0, 1'b0);
        set_cur(200, 0, 0, 0);
        cyc(0, 1); chk("sat_v1", {24'd0, membrane[7:0]}, 32'd200);
        cyc(0, 1); chk("sat_v2", {24'd0, membrane[7:0]}, 32'd255);
        cyc(0, 1); chk("sat_nospike", {28'd0, spike}, 32'd0);

        // Refractory period of 2 steps
        cyc(1, 0);
        set_cfg(50, 0, 2, 1'b0);
        set_cur(60, 0, 0, 0);
        cyc(0, 1); chk("ref_s1", {28'd0, spike}, 32'd1);
        cyc(0, 1); chk("ref_s2", {28'd0, spike}, 32'd0);
        chk("ref_v2", {24'd0, membrane[7:0]}, 32'd0);
        cyc(0, 1); chk("ref_s3", {28'd0, spike}, 32'd0);
        cyc(0, 1); chk("ref_s4", {28'd0, spike}, 32'd1);
        cyc(0, 1);
        // Reset mid-refractory overrides step; then accumulate from zero
        cyc(1, 1);
        chk("midref_membrane", membrane, 32'd0);
        chk("midref_total", {16'd0, spike_total}, 32'd0);
        set_cfg(100, 0, 2, 1'b0);
        cyc(0, 1); chk("post_reset_v", {24'd0, membrane[7:0]}, 32'd60);
        chk("post_reset_spike", {28'd0, spike}, 32'd0);

        // Randomised mixed-channel traffic checked against the model
        for (int n = 0; n < 60; n++) begin
            set_cur($urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 80), $urandom_range(0, 20));
            set_cfg($urandom_range(0, 255), $urandom_range(0, 7),
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            cyc(0, 1'($urandom_range(0, 3) != 0));
        end

        // All channels firing every step until the counter saturates
        cyc(1, 0);
        set_cfg(1, 0, 0, 1'b0);
        set_cur(255, 255, 255, 255);
        verbose = 1'b0;
        cyc(0, 1); chk("all_spike", {28'd0, spike}, 32'hF);
        chk("all_total", {16'd0, spike_total}, 32'd4);
        for (int n = 0; n < 16390; n++) cyc(0, 1);
        verbose = 1'b1;
        cyc(0, 1);
        chk("total_saturated", {16'd0, spike_total}, 32'd65535);
        chk("sat_all_spike", {28'd0, spike}, 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
